uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 25000, meaning max cycles allowed in each wait state before error.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nRst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req_a  input  1  player-guess requester wants to send data_a.
REQ-005 SHALL have port data_a  input  8  player-guess byte.
REQ-006 SHALL have port ack_a  output  1  one-cycle pulse: data_a latched, requester may drop req_a.
REQ-007 SHALL have port req_b  input  1  game-message requester wants to send data_b.
REQ-008 SHALL have port data_b  input  8  game-message byte.
REQ-009 SHALL have port ack_b  output  1  one-cycle pulse: data_b latched.
REQ-010 SHALL have port tx_ready  input  1  UART transmitter idle, high when it can accept a byte.
REQ-011 SHALL have port tx_start  output  1  one-cycle pulse starting a UART frame.
REQ-012 SHALL have port tx_data  output  8  byte to transmit, held stable from LOAD until return to IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse: frame completed.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port clr_err  input  1  clears the sticky error.
REQ-016 SHALL have port err_LED  output  1  sticky transmit-timeout flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, WAIT_BUSY, WAIT_DONE, ERROR.
REQ-018 IDLE: when tx_ready=1 and any req is high, SHALL latch the winner's byte into tx_data, pulse its ack, go to LOAD; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: single requester wins; both high -> the one not granted last wins; last-grant pointer resets to B (A wins first tie).
REQ-020 IDLE with tx_ready=0 SHALL grant nothing, no ack.
REQ-021 LOAD: tx_start=1 for exactly this cycle, next state WAIT_BUSY.
REQ-022 WAIT_BUSY: tx_ready=0 -> WAIT_DONE; counter reaching TIMEOUT -> ERROR.
REQ-023 WAIT_DONE: tx_ready=1 -> pulse done, go to IDLE; counter reaching TIMEOUT -> ERROR.
REQ-024 Timeout counter SHALL clear on entry to WAIT_BUSY and to WAIT_DONE, increment each cycle in them, width $clog2(TIMEOUT+1), never wrap.
REQ-025 ERROR: err_LED=1, no grants; clr_err=1 -> err_LED cleared, IDLE next cycle.
REQ-026 Requests arriving while busy SHALL be held off (no ack) and served in IDLE per REQ-019.
REQ-027 Grant-to-tx_start latency SHALL be exactly 1 cycle; IDLE-to-next-grant minimum 1 cycle after done.
REQ-028 clr_err outside ERROR SHALL have no effect.

Reset
REQ-029 On nRst=0: state IDLE, tx_start=0, ack_a=0, ack_b=0, done=0, busy=0, err_LED=0, tx_data=8'h00, counter=0, last-grant=B.
REQ-030 Reset mid-frame SHALL abort immediately; no done pulse, no ack re-issued after release.

Structure
REQ-031 State enum and requester-id type (REQ_A, REQ_B) SHALL live in shared package hangman_pkg.
REQ-032 Timeout counter SHALL be sub-module tx_watchdog (clear, enable, TIMEOUT parameter, expired output).

Verification
REQ-033 req_a=1, data_a=8'hA9, tx_ready=1 -> ack_a next edge, tx_start one cycle later with tx_data=8'hA9; drop tx_ready 3 cycles then raise -> done pulse, busy=0.
REQ-034 req_a and req_b high together after reset, data 8'h41/8'h42 -> order A, B, A on repeated ties; tx_data 8'h41, 8'h42, 8'h41.
REQ-035 TIMEOUT=10, tx_ready stays 1 after tx_start -> ERROR after 10 cycles in WAIT_BUSY, err_LED=1, requests ignored; clr_err pulse -> IDLE, err_LED=0.
REQ-036 tx_ready held 0 in IDLE with req_b=1 -> no ack_b; raise tx_ready -> ack_b within 1 cycle.
REQ-037 nRst pulsed low during WAIT_DONE -> all outputs at reset values asynchronously; no done after release.
REQ-038 req_b raised while busy serving A -> ack_b only after done, first cycle back in IDLE.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, requester
// identity and the round-robin selection helper.
package hangman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    ERROR
  } arb_state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_t;

  // Single requester wins outright; on a tie the one not granted last wins.
  function automatic req_id_t rr_pick(input logic    req_a,
                                      input logic    req_b,
                                      input req_id_t last);
    if (req_a && req_b) begin
      return (last == REQ_A) ? REQ_B : REQ_A;
    end else if (req_a) begin
      return REQ_A;
    end else begin
      return REQ_B;
    end
  endfunction

endpackage

// File: rtl/tx_watchdog.sv
// Saturating wait-state cycle counter; flags the last permitted cycle so the
// FSM leaves for ERROR exactly TIMEOUT cycles after entering a wait state.
module tx_watchdog #(
  parameter int unsigned TIMEOUT = 25000
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Asserted during the TIMEOUT-th cycle; the counter reaches TIMEOUT on the
  // same edge that moves the FSM to ERROR.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the player-guess
// (A) and game-message (B) requesters, with a sticky transmit-timeout flag.
module uart_tx_arbiter
  import hangman_pkg::*;
#(
  parameter int unsigned TIMEOUT = 25000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done,
  output logic       busy,
  input  logic       clr_err,
  output logic       err_LED
);

  arb_state_t state_q, state_d;
  req_id_t    last_q, last_d;
  req_id_t    winner;

  logic [7:0] tx_data_d;
  logic       ack_a_d, ack_b_d, tx_start_d, done_d, err_d;
  logic       wd_clr, wd_en, wd_exp;

  tx_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .nRst   (nRst),
    .clear  (wd_clr),
    .enable (wd_en),
    .expired(wd_exp)
  );

  assign winner = rr_pick(req_a, req_b, last_q);
  assign wd_en  = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    tx_data_d  = tx_data;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    err_d      = err_LED;
    wd_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_ready && (req_a || req_b)) begin
          last_d  = winner;
          state_d = LOAD;
          if (winner == REQ_A) begin
            tx_data_d = data_a;
            ack_a_d   = 1'b1;
          end else begin
            tx_data_d = data_b;
            ack_b_d   = 1'b1;
          end
        end
      end

      LOAD: begin
        tx_start_d = 1'b1;
        wd_clr     = 1'b1;
        state_d    = WAIT_BUSY;
      end

      // Transmitter acceptance (ready dropping) wins over a coincident timeout.
      WAIT_BUSY: begin
        if (!tx_ready) begin
          wd_clr  = 1'b1;
          state_d = WAIT_DONE;
        end else if (wd_exp) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end

      WAIT_DONE: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_exp) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end
      end

      ERROR: begin
        err_d = 1'b1;
        if (clr_err) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      last_q   <= REQ_B;
      tx_data  <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      err_LED  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tx_data  <= tx_data_d;
      ack_a    <= ack_a_d;
      ack_b    <= ack_b_d;
      tx_start <= tx_start_d;
      done     <= done_d;
      err_LED  <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with TIMEOUT=10.
module tb_uart_tx_arbiter;

  logic       tb_clk = 1'b0;
  logic       nRst;
  logic       req_a, req_b, tx_ready, clr_err;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, tx_start, done, busy, err_LED;
  logic [7:0] tx_data;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  uart_tx_arbiter #(
    .TIMEOUT(10)
  ) dut (
    .clk     (tb_clk),
    .nRst    (nRst),
    .req_a   (req_a),
    .data_a  (data_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .ack_b   (ack_b),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .done    (done),
    .busy    (busy),
    .clr_err (clr_err),
    .err_LED (err_LED)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".busy"},     busy,     0);
    check_eq({tag, ".ack_a"},    ack_a,    0);
    check_eq({tag, ".ack_b"},    ack_b,    0);
    check_eq({tag, ".tx_start"}, tx_start, 0);
    check_eq({tag, ".done"},     done,     0);
    check_eq({tag, ".err"},      err_LED,  0);
    check_eq({tag, ".tx_data"},  tx_data,  8'h00);
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    tick();
    tick();
    nRst = 1'b1;
    tick();
  endtask

  // Called in the LOAD cycle (ack visible); drives a minimal frame to done.
  task automatic finish_frame(input string tag, input logic [7:0] byte_exp);
    tick();
    check_eq({tag, ".tx_start"}, tx_start, 1);
    check_eq({tag, ".hold"},     tx_data,  byte_exp);
    tx_ready = 1'b0;
    tick();
    check_eq({tag, ".wait_ack"}, {ack_a, ack_b}, 2'b00);
    check_eq({tag, ".wait_busy"}, busy, 1);
    tx_ready = 1'b1;
    tick();
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    nRst = 1'b0; req_a = 0; req_b = 0; tx_ready = 0; clr_err = 0;
    data_a = 8'h00; data_b = 8'h00;
    tick();
    tick();
    check_idle_outputs("rst");
    nRst = 1'b1;
    tick();

    // Single A transfer, transmitter busy for 3 cycles.
    req_a = 1; data_a = 8'hA9; tx_ready = 1;
    tick();
    check_eq("a9.ack_a", ack_a, 1);
    check_eq("a9.data",  tx_data, 8'hA9);
    req_a = 0;
    tick();
    check_eq("a9.tx_start", tx_start, 1);
    check_eq("a9.ack_a_pulse", ack_a, 0);
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("a9.no_done", done, 0);
    end
    tx_ready = 1;
    tick();
    check_eq("a9.done", done, 1);
    check_eq("a9.busy", busy, 0);
    tick();
    check_eq("a9.done_pulse", done, 0);

    // Ties after reset alternate A, B, A.
    do_reset();
    req_a = 1; req_b = 1; data_a = 8'h41; data_b = 8'h42; tx_ready = 1;
    tick();
    check_eq("tie1.acks", {ack_a, ack_b}, 2'b10);
    check_eq("tie1.data", tx_data, 8'h41);
    finish_frame("tie1", 8'h41);
    tick();
    check_eq("tie2.acks", {ack_a, ack_b}, 2'b01);
    check_eq("tie2.data", tx_data, 8'h42);
    finish_frame("tie2", 8'h42);
    tick();
    check_eq("tie3.acks", {ack_a, ack_b}, 2'b10);
    check_eq("tie3.data", tx_data, 8'h41);
    finish_frame("tie3", 8'h41);
    req_a = 0; req_b = 0;
    tick();

    // B held off while the transmitter is not ready.
    tx_ready = 0; req_b = 1; data_b = 8'h5B;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("nrdy.ack_b", ack_b, 0);
      check_eq("nrdy.busy",  busy,  0);
    end
    tx_ready = 1;
    tick();
    check_eq("nrdy.ack_b_late", ack_b, 1);
    check_eq("nrdy.data", tx_data, 8'h5B);
    req_b = 0;
    finish_frame("nrdy", 8'h5B);
    tick();

    // B arriving mid-frame is served only once back in IDLE.
    req_a = 1; data_a = 8'h11; data_b = 8'h22;
    tick();
    check_eq("mid.ack_a", ack_a, 1);
    req_a = 0; req_b = 1;
    finish_frame("mid", 8'h11);
    check_eq("mid.ack_b_held", ack_b, 0);
    tick();
    check_eq("mid.ack_b", ack_b, 1);
    check_eq("mid.data", tx_data, 8'h22);
    req_b = 0;
    finish_frame("mid2", 8'h22);
    tick();

    // Timeout: tx_ready never drops after tx_start.
    req_a = 1; data_a = 8'h55;
    tick();
    check_eq("to.ack_a", ack_a, 1);
    req_a = 0;
    tick();
    check_eq("to.tx_start", tx_start, 1);
    for (int i = 0; i < 9; i++) begin
      clr_err = (i >= 5);
      tick();
    end
    check_eq("to.err_early", err_LED, 0);
    check_eq("to.busy_early", busy, 1);
    clr_err = 0;
    tick();
    check_eq("to.err", err_LED, 1);
    req_a = 1; req_b = 1; data_b = 8'h66;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("to.no_grant", {ack_a, ack_b}, 2'b00);
      check_eq("to.sticky", err_LED, 1);
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    check_eq("to.cleared", err_LED, 0);
    check_eq("to.idle", busy, 0);
    tick();
    check_eq("to.rr_after", {ack_a, ack_b}, 2'b01);
    check_eq("to.rr_data", tx_data, 8'h66);
    req_a = 0; req_b = 0;
    finish_frame("to2", 8'h66);
    tick();

    // Reset during WAIT_DONE aborts the frame asynchronously.
    req_a = 1; data_a = 8'h77;
    tick();
    req_a = 0;
    tick();
    tx_ready = 0;
    tick();
    check_eq("ar.in_wait", busy, 1);
    #2 nRst = 1'b0;
    #1;
    check_idle_outputs("ar");
    tick();
    tx_ready = 1;
    nRst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ar.no_done", done, 0);
      check_eq("ar.no_ack",  {ack_a, ack_b}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
